// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared constants, ALU codes and kill-FSM states for the decode stage
package decode_pkg;

    localparam int REG_W    = 5;
    localparam int ALUOP_W  = 4;
    localparam int ALUSEL_W = 3;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [ALUOP_W-1:0] ALU_NOP_OP   = 4'd0;
    localparam logic [ALUOP_W-1:0] ALU_ADD_OP   = 4'd1;
    localparam logic [ALUOP_W-1:0] ALU_SUB_OP   = 4'd2;
    localparam logic [ALUOP_W-1:0] ALU_SLL_OP   = 4'd3;
    localparam logic [ALUOP_W-1:0] ALU_SLT_OP   = 4'd4;
    localparam logic [ALUOP_W-1:0] ALU_SLTU_OP  = 4'd5;
    localparam logic [ALUOP_W-1:0] ALU_XOR_OP   = 4'd6;
    localparam logic [ALUOP_W-1:0] ALU_SRL_OP   = 4'd7;
    localparam logic [ALUOP_W-1:0] ALU_SRA_OP   = 4'd8;
    localparam logic [ALUOP_W-1:0] ALU_OR_OP    = 4'd9;
    localparam logic [ALUOP_W-1:0] ALU_AND_OP   = 4'd10;
    localparam logic [ALUOP_W-1:0] ALU_LOAD_OP  = 4'd11;
    localparam logic [ALUOP_W-1:0] ALU_STORE_OP = 4'd12;
    localparam logic [ALUOP_W-1:0] ALU_JAL_OP   = 4'd13;
    localparam logic [ALUOP_W-1:0] ALU_BR_OP    = 4'd14;

    localparam logic [ALUSEL_W-1:0] ALU_NOP_SEL    = 3'd0;
    localparam logic [ALUSEL_W-1:0] ALU_ARITH_SEL  = 3'd1;
    localparam logic [ALUSEL_W-1:0] ALU_LOGIC_SEL  = 3'd2;
    localparam logic [ALUSEL_W-1:0] ALU_SHIFT_SEL  = 3'd3;
    localparam logic [ALUSEL_W-1:0] ALU_CMP_SEL    = 3'd4;
    localparam logic [ALUSEL_W-1:0] ALU_MEM_SEL    = 3'd5;
    localparam logic [ALUSEL_W-1:0] ALU_JUMP_SEL   = 3'd6;
    localparam logic [ALUSEL_W-1:0] ALU_BRANCH_SEL = 3'd7;

    typedef enum logic {ST_RUN, ST_KILL} kill_state_t;

    // alt selects SUB over ADD and SRA over SRL (instruction bit 30)
    function automatic logic [ALUOP_W-1:0] alu_op_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            F3_ADD:  alu_op_f3 = alt ? ALU_SUB_OP : ALU_ADD_OP;
            F3_SLL:  alu_op_f3 = ALU_SLL_OP;
            F3_SLT:  alu_op_f3 = ALU_SLT_OP;
            F3_SLTU: alu_op_f3 = ALU_SLTU_OP;
            F3_XOR:  alu_op_f3 = ALU_XOR_OP;
            F3_SR:   alu_op_f3 = alt ? ALU_SRA_OP : ALU_SRL_OP;
            F3_OR:   alu_op_f3 = ALU_OR_OP;
            default: alu_op_f3 = ALU_AND_OP;
        endcase
    endfunction

    function automatic logic [ALUSEL_W-1:0] alu_sel_of(input logic [ALUOP_W-1:0] op);
        case (op)
            ALU_ADD_OP, ALU_SUB_OP:             alu_sel_of = ALU_ARITH_SEL;
            ALU_SLL_OP, ALU_SRL_OP, ALU_SRA_OP: alu_sel_of = ALU_SHIFT_SEL;
            ALU_SLT_OP, ALU_SLTU_OP:            alu_sel_of = ALU_CMP_SEL;
            ALU_XOR_OP, ALU_OR_OP, ALU_AND_OP:  alu_sel_of = ALU_LOGIC_SEL;
            ALU_LOAD_OP, ALU_STORE_OP:          alu_sel_of = ALU_MEM_SEL;
            ALU_JAL_OP:                         alu_sel_of = ALU_JUMP_SEL;
            ALU_BR_OP:                          alu_sel_of = ALU_BRANCH_SEL;
            default:                            alu_sel_of = ALU_NOP_SEL;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_fwd_mux.sv
// rtl/decode_stage_fwd_mux.sv - per-operand forwarding mux with x0 rule and priority select
module fwd_mux
    import decode_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NFWD = 2
) (
    input  logic [REG_W-1:0]      addr,
    input  logic [XLEN-1:0]       rf_data,
    input  logic [NFWD-1:0]       fw_we,
    input  logic [REG_W*NFWD-1:0] fw_addr,
    input  logic [XLEN*NFWD-1:0]  fw_data,
    output logic [XLEN-1:0]       data
);

    // scan oldest to youngest so the lowest matching index wins; x0 overrides everything
    always_comb begin
        data = rf_data;
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (fw_we[i] && (fw_addr[REG_W*i +: REG_W] == addr)) begin
                data = fw_data[XLEN*i +: XLEN];
            end
        end
        if (addr == '0) begin
            data = '0;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I decode with ID/EX register, forwarding, load-use stall and branch kill
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int NFWD        = 2,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_inst,
    input  logic [XLEN-1:0]        in_pc,
    output logic                   rf_re1,
    output logic                   rf_re2,
    output logic [4:0]             rf_raddr1,
    output logic [4:0]             rf_raddr2,
    input  logic [XLEN-1:0]        rf_rdata1,
    input  logic [XLEN-1:0]        rf_rdata2,
    input  logic [NFWD-1:0]        fw_we,
    input  logic [5*NFWD-1:0]      fw_addr,
    input  logic [XLEN*NFWD-1:0]   fw_data,
    input  logic                   ex_is_load,
    input  logic [4:0]             ex_rd,
    input  logic                   flush,
    output logic                   redirect_valid,
    output logic [XLEN-1:0]        redirect_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ALUOP_W-1:0]     out_aluop,
    output logic [ALUSEL_W-1:0]    out_alusel,
    output logic [XLEN-1:0]        out_op1,
    output logic [XLEN-1:0]        out_op2,
    output logic [XLEN-1:0]        out_sdata,
    output logic                   out_wreg,
    output logic [4:0]             out_waddr,
    output logic [XLEN-1:0]        out_pc,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    logic [6:0]          opcode;
    logic [2:0]          f3;
    logic [4:0]          rd, rs1, rs2;
    logic [XLEN-1:0]     imm_i, imm_s, imm_b, imm_j, imm_u;
    logic [XLEN-1:0]     rs1_val, rs2_val;
    logic [ALUOP_W-1:0]  d_aluop;
    logic [ALUSEL_W-1:0] d_alusel;
    logic [XLEN-1:0]     d_op1, d_op2, d_sdata, target;
    logic                d_wreg, is_jal, is_jalr, is_br, br_cond, taken;
    logic [4:0]          d_waddr;
    logic                hazard, advance, accept, kill_fire;
    kill_state_t         state, state_next;

    assign opcode = in_inst[6:0];
    assign f3     = in_inst[14:12];
    assign rd     = in_inst[11:7];
    assign rs1    = in_inst[19:15];
    assign rs2    = in_inst[24:20];

    // immediates are assembled at 32 bits then sign-extended to XLEN
    assign imm_i = XLEN'($signed({{20{in_inst[31]}}, in_inst[31:20]}));
    assign imm_s = XLEN'($signed({{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]}));
    assign imm_b = XLEN'($signed({{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
    assign imm_j = XLEN'($signed({{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}));
    assign imm_u = XLEN'($signed({in_inst[31:12], 12'b0}));

    assign rf_raddr1 = rs1;
    assign rf_raddr2 = rs2;

    fwd_mux #(.XLEN(XLEN), .NFWD(NFWD)) u_fwd1 (
        .addr(rs1), .rf_data(rf_rdata1), .fw_we(fw_we), .fw_addr(fw_addr), .fw_data(fw_data), .data(rs1_val)
    );

    fwd_mux #(.XLEN(XLEN), .NFWD(NFWD)) u_fwd2 (
        .addr(rs2), .rf_data(rf_rdata2), .fw_we(fw_we), .fw_addr(fw_addr), .fw_data(fw_data), .data(rs2_val)
    );

    // instruction decode and operand selection
    always_comb begin
        d_aluop = ALU_NOP_OP;
        d_op1   = '0;
        d_op2   = '0;
        d_sdata = '0;
        d_wreg  = 1'b0;
        rf_re1  = 1'b0;
        rf_re2  = 1'b0;
        is_jal  = 1'b0;
        is_jalr = 1'b0;
        is_br   = 1'b0;
        case (opcode)
            OPC_OP: begin
                rf_re1 = 1'b1; rf_re2 = 1'b1;
                d_aluop = alu_op_f3(f3, in_inst[30]);
                d_op1 = rs1_val; d_op2 = rs2_val; d_wreg = 1'b1;
            end
            OPC_OPIMM: begin
                rf_re1 = 1'b1;
                d_aluop = alu_op_f3(f3, in_inst[30] && (f3 == F3_SR));
                d_op1 = rs1_val; d_op2 = imm_i; d_wreg = 1'b1;
            end
            OPC_LOAD: begin
                rf_re1 = 1'b1;
                d_aluop = ALU_LOAD_OP;
                d_op1 = rs1_val; d_op2 = imm_i; d_wreg = 1'b1;
            end
            OPC_STORE: begin
                rf_re1 = 1'b1; rf_re2 = 1'b1;
                d_aluop = ALU_STORE_OP;
                d_op1 = rs1_val; d_op2 = imm_s; d_sdata = rs2_val;
            end
            OPC_LUI: begin
                d_aluop = ALU_ADD_OP; d_op2 = imm_u; d_wreg = 1'b1;
            end
            OPC_AUIPC: begin
                d_aluop = ALU_ADD_OP; d_op1 = in_pc; d_op2 = imm_u; d_wreg = 1'b1;
            end
            OPC_JAL: begin
                is_jal = 1'b1;
                d_aluop = ALU_JAL_OP; d_op1 = in_pc; d_op2 = XLEN'(4); d_wreg = 1'b1;
            end
            OPC_JALR: begin
                rf_re1 = 1'b1; is_jalr = 1'b1;
                d_aluop = ALU_JAL_OP; d_op1 = in_pc; d_op2 = XLEN'(4); d_wreg = 1'b1;
            end
            OPC_BRANCH: begin
                rf_re1 = 1'b1; rf_re2 = 1'b1; is_br = 1'b1;
                d_aluop = ALU_BR_OP; d_op1 = rs1_val; d_op2 = rs2_val;
            end
            default: ;
        endcase
        d_alusel = alu_sel_of(d_aluop);
        d_waddr  = d_wreg ? rd : 5'd0;
    end

    // branch condition and control-flow target
    always_comb begin
        case (f3)
            F3_BEQ:  br_cond = (rs1_val == rs2_val);
            F3_BNE:  br_cond = (rs1_val != rs2_val);
            F3_BLT:  br_cond = ($signed(rs1_val) <  $signed(rs2_val));
            F3_BGE:  br_cond = ($signed(rs1_val) >= $signed(rs2_val));
            F3_BLTU: br_cond = (rs1_val <  rs2_val);
            F3_BGEU: br_cond = (rs1_val >= rs2_val);
            default: br_cond = 1'b0;
        endcase
        taken = is_jal || is_jalr || (is_br && br_cond);
        if (is_jalr) begin
            target = (rs1_val + imm_i) & ~XLEN'(1);
        end else if (is_jal) begin
            target = in_pc + imm_j;
        end else begin
            target = in_pc + imm_b;
        end
    end

    assign hazard = ex_is_load && (ex_rd != 5'd0) &&
                    ((rf_re1 && (rs1 == ex_rd)) || (rf_re2 && (rs2 == ex_rd)));
    assign advance   = !out_valid || out_ready;
    assign in_ready  = !hazard && advance;
    assign accept    = in_valid && in_ready;
    assign kill_fire = accept && taken && (state == ST_RUN) && !flush;

    // kill-FSM next state: flush wins, then taken-transfer arms, then one drop disarms
    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = ST_RUN;
        end else begin
            case (state)
                ST_RUN:  if (accept && taken) state_next = ST_KILL;
                ST_KILL: if (accept) state_next = ST_RUN;
                default: state_next = ST_RUN;
            endcase
        end
    end

    // kill-FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // ID/EX register: load decoded instruction or a bubble when the slot advances
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_aluop  <= ALU_NOP_OP;
            out_alusel <= ALU_NOP_SEL;
            out_op1    <= '0;
            out_op2    <= '0;
            out_sdata  <= '0;
            out_wreg   <= 1'b0;
            out_waddr  <= '0;
            out_pc     <= '0;
        end else if (flush || (advance && !(accept && state == ST_RUN))) begin
            out_valid  <= 1'b0;
            out_aluop  <= ALU_NOP_OP;
            out_alusel <= ALU_NOP_SEL;
            out_wreg   <= 1'b0;
        end else if (advance) begin
            out_valid  <= 1'b1;
            out_aluop  <= d_aluop;
            out_alusel <= d_alusel;
            out_op1    <= d_op1;
            out_op2    <= d_op2;
            out_sdata  <= d_sdata;
            out_wreg   <= d_wreg;
            out_waddr  <= d_waddr;
            out_pc     <= in_pc;
        end
    end

    // one-cycle redirect pulse for a taken transfer accepted on the right path
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            redirect_valid <= kill_fire;
            if (kill_fire) begin
                redirect_pc <= target;
            end
        end
    end

    // saturating count of load-use bubbles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (hazard && in_valid && advance && !flush && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + STALL_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed scoreboard bench for decode_stage
module tb_decode_stage;
    import decode_pkg::*;

    localparam int XLEN = 32;
    localparam int NFWD = 2;
    localparam int SCW  = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid, in_ready;
    logic [31:0] in_inst, in_pc;
    logic rf_re1, rf_re2;
    logic [4:0] rf_raddr1, rf_raddr2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic [NFWD-1:0] fw_we;
    logic [5*NFWD-1:0] fw_addr;
    logic [XLEN*NFWD-1:0] fw_data;
    logic ex_is_load;
    logic [4:0] ex_rd;
    logic flush;
    logic redirect_valid;
    logic [31:0] redirect_pc;
    logic out_valid, out_ready;
    logic [ALUOP_W-1:0] out_aluop;
    logic [ALUSEL_W-1:0] out_alusel;
    logic [31:0] out_op1, out_op2, out_sdata, out_pc;
    logic out_wreg;
    logic [4:0] out_waddr;
    logic [SCW-1:0] stall_cnt;

    typedef struct {
        logic [ALUOP_W-1:0]  aluop;
        logic [ALUSEL_W-1:0] alusel;
        logic [31:0]         op1, op2, sdata;
        logic                wreg;
        logic [4:0]          waddr;
        logic [31:0]         pc;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    logic [31:0] rf [32];

    assign rf_rdata1 = rf[rf_raddr1];
    assign rf_rdata2 = rf[rf_raddr2];

    always #5 clk = ~clk;

    decode_stage #(.XLEN(XLEN), .NFWD(NFWD), .STALL_CNT_W(SCW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .rf_re1(rf_re1), .rf_re2(rf_re2), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .fw_we(fw_we), .fw_addr(fw_addr), .fw_data(fw_data),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_aluop(out_aluop), .out_alusel(out_alusel), .out_op1(out_op1), .out_op2(out_op2),
        .out_sdata(out_sdata), .out_wreg(out_wreg), .out_waddr(out_waddr), .out_pc(out_pc),
        .stall_cnt(stall_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [ALUOP_W-1:0] op, input logic [ALUSEL_W-1:0] sel,
                                input logic [31:0] a, input logic [31:0] b, input logic [31:0] sd,
                                input logic w, input logic [4:0] wa, input logic [31:0] pc);
        exp_t e;
        e.aluop = op; e.alusel = sel; e.op1 = a; e.op2 = b; e.sdata = sd;
        e.wreg = w; e.waddr = wa; e.pc = pc;
        return e;
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    // drive one instruction until it is accepted; optionally register its expected output
    task automatic issue(input logic [31:0] inst, input logic [31:0] pc, input bit push, input exp_t e);
        bit acc;
        acc = 1'b0;
        in_inst = inst; in_pc = pc; in_valid = 1'b1;
        if (push) q.push_back(e);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        chk("issue_accepted", {63'b0, acc}, 64'd1);
        in_valid = 1'b0;
    endtask

    // scoreboard: every transfer out of ID/EX must match the oldest expected instruction
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("out_unexpected_valid", {63'b0, out_valid}, 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("out_aluop", out_aluop, e.aluop);
                chk("out_alusel", out_alusel, e.alusel);
                chk("out_op1", out_op1, e.op1);
                chk("out_op2", out_op2, e.op2);
                chk("out_sdata", out_sdata, e.sdata);
                chk("out_wreg", out_wreg, e.wreg);
                chk("out_waddr", out_waddr, e.waddr);
                chk("out_pc", out_pc, e.pc);
            end
        end
    end

    task automatic chk_reset_values(input string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_aluop"}, out_aluop, ALU_NOP_OP);
        chk({tag, "_out_alusel"}, out_alusel, ALU_NOP_SEL);
        chk({tag, "_out_wreg"}, out_wreg, 0);
        chk({tag, "_out_op1"}, out_op1, 0);
        chk({tag, "_out_op2"}, out_op2, 0);
        chk({tag, "_out_sdata"}, out_sdata, 0);
        chk({tag, "_out_waddr"}, out_waddr, 0);
        chk({tag, "_out_pc"}, out_pc, 0);
        chk({tag, "_redirect_valid"}, redirect_valid, 0);
        chk({tag, "_redirect_pc"}, redirect_pc, 0);
        chk({tag, "_stall_cnt"}, stall_cnt, 0);
    endtask

    initial begin
        exp_t e;
        for (int i = 0; i < 32; i++) rf[i] = 32'(i * 16);
        rf[5] = 32'h203;
        rst_n = 1'b0; in_valid = 1'b0; in_inst = 32'h13; in_pc = 0;
        fw_we = '0; fw_addr = '0; fw_data = '0;
        ex_is_load = 1'b0; ex_rd = 0; flush = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_values("reset");
        rst_n = 1'b1;
        chk("reset_in_ready", in_ready, 1);

        // ADDI x1,x0,5
        issue(enc_i(12'd5, 5'd0, F3_ADD, 5'd1, OPC_OPIMM), 32'h0, 1,
              mk(ALU_ADD_OP, ALU_ARITH_SEL, 0, 5, 0, 1, 1, 32'h0));
        // ADD x2,x1,x1 with x1=5 forwarded on source 0
        fw_we = 2'b01; fw_addr = {5'd0, 5'd1}; fw_data = {32'd0, 32'd5};
        issue(enc_r(7'd0, 5'd1, 5'd1, F3_ADD, 5'd2), 32'h4, 1,
              mk(ALU_ADD_OP, ALU_ARITH_SEL, 5, 5, 0, 1, 2, 32'h4));
        chk("fwd_op1_after_accept", out_op1, 5);
        // both sources target x3: index 0 wins
        fw_we = 2'b11; fw_addr = {5'd3, 5'd3}; fw_data = {32'd9, 32'd7};
        issue(enc_r(7'd0, 5'd3, 5'd3, F3_ADD, 5'd4), 32'h8, 1,
              mk(ALU_ADD_OP, ALU_ARITH_SEL, 7, 7, 0, 1, 4, 32'h8));
        // x0 is never forwarded
        fw_addr = {5'd0, 5'd0}; fw_data = {32'd9, 32'd9};
        issue(enc_r(7'b0100000, 5'd0, 5'd0, F3_ADD, 5'd5), 32'hC, 1,
              mk(ALU_SUB_OP, ALU_ARITH_SEL, 0, 0, 0, 1, 5, 32'hC));
        fw_we = 2'b00;

        // load-use on x4: one bubble, one stall count
        ex_is_load = 1'b1; ex_rd = 5'd4;
        e = mk(ALU_ADD_OP, ALU_ARITH_SEL, 32'h40, 32'h10, 0, 1, 6, 32'h10);
        in_inst = enc_r(7'd0, 5'd1, 5'd4, F3_ADD, 5'd6); in_pc = 32'h10; in_valid = 1'b1;
        q.push_back(e);
        @(negedge clk);
        chk("hazard_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        ex_is_load = 1'b0;
        chk("hazard_bubble_valid", out_valid, 0);
        chk("hazard_stall_cnt", stall_cnt, 1);
        issue(in_inst, in_pc, 0, e);
        chk("hazard_stall_cnt_hold", stall_cnt, 1);

        // BEQ x1,x2,+16 with equal forwarded operands
        fw_we = 2'b11; fw_addr = {5'd2, 5'd1}; fw_data = {32'h55, 32'h55};
        issue(enc_b(13'd16, 5'd2, 5'd1, F3_BEQ), 32'h100, 1,
              mk(ALU_BR_OP, ALU_BRANCH_SEL, 32'h55, 32'h55, 0, 0, 0, 32'h100));
        fw_we = 2'b00;
        chk("beq_redirect_valid", redirect_valid, 1);
        chk("beq_redirect_pc", redirect_pc, 32'h110);
        in_inst = enc_i(12'd1, 5'd0, F3_ADD, 5'd7, OPC_OPIMM); in_pc = 32'h104; in_valid = 1'b1;
        @(negedge clk);
        chk("kill_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("beq_redirect_pulse_end", redirect_valid, 0);
        chk("kill_dropped", out_valid, 0);
        issue(enc_i(12'd1, 5'd0, F3_ADD, 5'd7, OPC_OPIMM), 32'h110, 1,
              mk(ALU_ADD_OP, ALU_ARITH_SEL, 0, 1, 0, 1, 7, 32'h110));

        // JALR x1,8(x5) with x5=0x203, then hold with out_ready=0
        issue(enc_i(12'd8, 5'd5, 3'b000, 5'd1, OPC_JALR), 32'h200, 1,
              mk(ALU_JAL_OP, ALU_JUMP_SEL, 32'h200, 4, 0, 1, 1, 32'h200));
        out_ready = 1'b0;
        chk("jalr_redirect_valid", redirect_valid, 1);
        chk("jalr_redirect_pc", redirect_pc, 32'h20A);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk("hold_out_valid", out_valid, 1);
            chk("hold_out_op1", out_op1, 32'h200);
            chk("hold_out_op2", out_op2, 4);
            chk("hold_out_wreg", out_wreg, 1);
            chk("hold_out_pc", out_pc, 32'h200);
            chk("hold_in_ready", in_ready, 0);
        end
        // asynchronous reset in the middle of KILL
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_values("midkill");
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        issue(enc_i(12'd3, 5'd0, F3_ADD, 5'd8, OPC_OPIMM), 32'h300, 1,
              mk(ALU_ADD_OP, ALU_ARITH_SEL, 0, 3, 0, 1, 8, 32'h300));
        chk("post_reset_run_valid", out_valid, 1);

        // flush drops the instruction accepted in the same cycle
        in_inst = enc_i(12'd1, 5'd0, F3_ADD, 5'd9, OPC_OPIMM); in_pc = 32'h400;
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_no_redirect", redirect_valid, 0);

        // JAL x1,+8 then flush while in KILL
        issue(enc_j(21'd8, 5'd1), 32'h500, 1,
              mk(ALU_JAL_OP, ALU_JUMP_SEL, 32'h500, 4, 0, 1, 1, 32'h500));
        chk("jal_redirect_pc", redirect_pc, 32'h508);
        in_inst = enc_i(12'd2, 5'd0, F3_ADD, 5'd10, OPC_OPIMM); in_pc = 32'h504;
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_kill_out_valid", out_valid, 0);
        issue(enc_i(12'd4, 5'd0, F3_ADD, 5'd11, OPC_OPIMM), 32'h600, 1,
              mk(ALU_ADD_OP, ALU_ARITH_SEL, 0, 4, 0, 1, 11, 32'h600));
        // unknown opcode passes as a NOP
        issue(32'h0000_007F, 32'h604, 1, mk(ALU_NOP_OP, ALU_NOP_SEL, 0, 0, 0, 0, 0, 32'h604));
        // SW x2,12(x1)
        issue(enc_s(12'd12, 5'd2, 5'd1, 3'b010), 32'h608, 1,
              mk(ALU_STORE_OP, ALU_MEM_SEL, 32'h10, 12, 32'h20, 0, 0, 32'h608));

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
